// File: rtl/ifu_fetch_stage.sv
// ---------------------------------------------------------------------------
// ifu_fetch_stage
//
// Instruction fetch stage of the npc core. Owns the PC, issues one AXI-Lite
// read per instruction to the icache, and presents {pc, inst, fault} to the
// decode stage over a valid/ready handshake. Redirects from the back end
// (branch/jump/trap/fence.i refetch) squash whatever fetch is in flight.
//
// Optional build macro:
//   IFU_PERF_EN - adds 64-bit performance counters perf_fetch_cnt,
//                 perf_stall_cnt and perf_squash_cnt.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ic_araddr/arvalid/arready  icache read address channel
//   ic_rdata/rresp/rvalid/rready  icache read data channel
//   redirect_valid/redirect_pc    refetch request from the back end
//   id_valid/id_ready             handshake to the decode stage
//   id_pc/id_inst/id_fault        presented instruction
//   perf_*_cnt (IFU_PERF_EN only) performance counters
// ---------------------------------------------------------------------------
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [1:0]  OKAY_RESP = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ic_araddr,
    output logic        ic_arvalid,
    input  logic        ic_arready,
    input  logic [31:0] ic_rdata,
    input  logic [1:0]  ic_rresp,
    input  logic        ic_rvalid,
    output logic        ic_rready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
`ifdef IFU_PERF_EN
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt,
    output logic [63:0] perf_squash_cnt,
`endif
    output logic        id_fault
);

    typedef enum logic [1:0] {
        ST_ADDR   = 2'd0,
        ST_WAIT_R = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    logic        r_drop;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_fault;

    logic [31:0] w_redir_tgt;
    logic [31:0] w_pc_inc;
    logic [31:0] w_next_pc;
    logic        w_ar_hs;
    logic        w_resp;
    logic        w_discard;
    logic        w_fire;

    assign w_redir_tgt = {redirect_pc[31:2], 2'b00};
    assign w_pc_inc    = r_pc + 32'd4;
    // After a discarded response the fetch restarts from the newest PC, which
    // is the redirect target if one arrives in that very cycle.
    assign w_next_pc   = redirect_valid ? w_redir_tgt : r_pc;

    assign w_ar_hs   = (r_state == ST_ADDR) && ic_arready;
    // The icache may return hit data in the same cycle the AR is accepted.
    assign w_resp    = (w_ar_hs && ic_rvalid) || ((r_state == ST_WAIT_R) && ic_rvalid);
    assign w_discard = w_resp && (r_drop || redirect_valid);
    assign w_fire    = id_valid && id_ready;

    assign ic_arvalid = (r_state == ST_ADDR);
    assign ic_araddr  = r_req_addr;
    assign ic_rready  = (r_state != ST_HOLD);
    // A redirect in HOLD must never let the stale instruction reach decode.
    assign id_valid   = (r_state == ST_HOLD) && !redirect_valid;
    assign id_pc      = r_id_pc;
    assign id_inst    = r_id_inst;
    assign id_fault   = r_id_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ADDR;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_drop     <= 1'b0;
            r_id_pc    <= 32'd0;
            r_id_inst  <= 32'd0;
            r_id_fault <= 1'b0;
        end else if (w_resp) begin
            if (w_discard) begin
                r_drop     <= 1'b0;
                r_pc       <= w_next_pc;
                r_req_addr <= w_next_pc;
                r_state    <= ST_ADDR;
            end else begin
                r_id_inst  <= ic_rdata;
                r_id_pc    <= r_req_addr;
                r_id_fault <= (ic_rresp != OKAY_RESP);
                r_state    <= ST_HOLD;
            end
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_state <= ST_WAIT_R;
                    end
                    if (redirect_valid) begin
                        // An unaccepted AR must keep its address stable, so
                        // only the PC moves; the old response gets dropped.
                        r_drop <= 1'b1;
                        r_pc   <= w_redir_tgt;
                        if (w_ar_hs) begin
                            r_req_addr <= w_redir_tgt;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (redirect_valid) begin
                        r_drop     <= 1'b1;
                        r_pc       <= w_redir_tgt;
                        r_req_addr <= w_redir_tgt;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        r_pc       <= w_redir_tgt;
                        r_req_addr <= w_redir_tgt;
                        r_state    <= ST_ADDR;
                    end else if (id_ready) begin
                        r_pc       <= w_pc_inc;
                        r_req_addr <= w_pc_inc;
                        r_state    <= ST_ADDR;
                    end
                end
                default: begin
                    r_state <= ST_ADDR;
                end
            endcase
        end
    end

`ifdef IFU_PERF_EN
    logic [63:0] r_perf_fetch;
    logic [63:0] r_perf_stall;
    logic [63:0] r_perf_squash;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch  <= 64'd0;
            r_perf_stall  <= 64'd0;
            r_perf_squash <= 64'd0;
        end else begin
            if (w_fire) begin
                r_perf_fetch <= r_perf_fetch + 64'd1;
            end
            if ((r_state != ST_HOLD) && !r_drop) begin
                r_perf_stall <= r_perf_stall + 64'd1;
            end
            if (w_discard) begin
                r_perf_squash <= r_perf_squash + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch;
    assign perf_stall_cnt  = r_perf_stall;
    assign perf_squash_cnt = r_perf_squash;
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_stage
//
// Bench for ifu_fetch_stage. A small icache model answers reads either as a
// same-cycle hit or as a delayed miss; instruction words are derived from
// the address so every presented instruction can be predicted. Expected
// decode-side transfers are queued when a scenario is set up and compared
// as the DUT fires them.
// ---------------------------------------------------------------------------
module tb_ifu_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ic_araddr;
    logic        ic_arvalid;
    logic        ic_arready;
    logic [31:0] ic_rdata;
    logic [1:0]  ic_rresp;
    logic        ic_rvalid;
    logic        ic_rready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fault;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
    logic [63:0] perf_squash_cnt;
`endif

    always #5 clk = ~clk;

    ifu_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ic_araddr      (ic_araddr),
        .ic_arvalid     (ic_arvalid),
        .ic_arready     (ic_arready),
        .ic_rdata       (ic_rdata),
        .ic_rresp       (ic_rresp),
        .ic_rvalid      (ic_rvalid),
        .ic_rready      (ic_rready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
`ifdef IFU_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_squash_cnt(perf_squash_cnt),
`endif
        .id_fault       (id_fault)
    );

    // ---------------- icache model ----------------
    logic        hit_mode;
    logic        ar_block;
    logic [31:0] fault_addr;
    logic        m_rvalid;
    logic [31:0] m_addr;
    logic        m_pend;
    int          m_cnt;
    int          miss_delay = 10;
    logic [31:0] w_raddr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    assign ic_arready = !ar_block;
    assign ic_rvalid  = hit_mode ? (ic_arvalid && !ar_block) : m_rvalid;
    assign w_raddr    = hit_mode ? ic_araddr : m_addr;
    assign ic_rdata   = inst_of(w_raddr);
    assign ic_rresp   = (w_raddr == fault_addr) ? 2'b10 : 2'b00;

    initial begin
        m_rvalid = 1'b0;
        m_addr   = 32'd0;
        m_pend   = 1'b0;
        m_cnt    = 0;
        forever begin
            @(negedge clk);
            m_rvalid = 1'b0;
            if (rst) begin
                m_pend = 1'b0;
                m_cnt  = 0;
            end else if (!hit_mode) begin
                if (m_pend) begin
                    if (m_cnt == 0) begin
                        m_rvalid = 1'b1;
                        m_pend   = 1'b0;
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end else if (ic_arvalid && ic_arready) begin
                    m_pend = 1'b1;
                    m_addr = ic_araddr;
                    m_cnt  = miss_delay - 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic fault);
        exp_t e;
        e.pc    = pc;
        e.inst  = inst_of(pc);
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    check("fire_without_expect", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_inst", id_inst, e.inst);
                    check("id_fault", 32'(id_fault), 32'(e.fault));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic hm, input logic rdy);
        rst            = 1'b1;
        hit_mode       = hm;
        id_ready       = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        ar_block       = 1'b0;
        fault_addr     = 32'hFFFF_FFFF;
        exp_q.delete();
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Wait (bounded) until the scoreboard holds at most n entries.
    task automatic wait_q(input int n, input int maxc, input string tag);
        int k;
        k = 0;
        while (exp_q.size() > n && k < maxc) begin
            step();
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int k;
`ifdef IFU_PERF_EN
        logic [63:0] pf0;
        logic [63:0] ps0;
`endif

        // Reset state and back-to-back hits
        do_reset(1'b1, 1'b1);
        push_exp(32'h8000_0000, 1'b0);
        push_exp(32'h8000_0004, 1'b0);
        push_exp(32'h8000_0008, 1'b0);
        check("rst_arvalid", 32'(ic_arvalid), 32'd1);
        check("rst_araddr", ic_araddr, RESET_PC);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        check("rst_id_fault", 32'(id_fault), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hit_vld_pattern", 32'(id_valid), 32'(i % 2));
            step();
        end
        id_ready = 1'b0;
        check("hit_q_drained", 32'(exp_q.size()), 32'd0);

        // Miss with HOLD back-pressure
        do_reset(1'b0, 1'b0);
        push_exp(32'h8000_0000, 1'b0);
        step();
        @(negedge clk);
        check("miss_arvalid_wait", 32'(ic_arvalid), 32'd0);
        check("miss_rready_wait", 32'(ic_rready), 32'd1);
        k = 0;
        while (!id_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("miss_hold_reached", 32'(id_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            check("hold_valid", 32'(id_valid), 32'd1);
            check("hold_pc", id_pc, 32'h8000_0000);
            check("hold_inst", id_inst, 32'h0000_0013);
        end
        step();
        id_ready = 1'b1;
        wait_q(0, 5, "miss_fire");
        id_ready = 1'b0;

        // Redirect while waiting for a miss response
        do_reset(1'b0, 1'b1);
        push_exp(32'h8000_0100, 1'b0);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ic_arvalid && k < 30);
        check("wr_redir_ar_seen", 32'(ic_arvalid), 32'd1);
        check("wr_redir_araddr", ic_araddr, 32'h8000_0100);
        wait_q(0, 40, "wr_redir_fire");
        id_ready = 1'b0;

        // Redirect in HOLD while decode is ready
        do_reset(1'b1, 1'b0);
        push_exp(32'h8000_0200, 1'b0);
        step();
`ifdef IFU_PERF_EN
        pf0 = perf_fetch_cnt;
        ps0 = perf_squash_cnt;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        id_ready       = 1'b1;
        @(negedge clk);
        check("hold_redir_no_valid", 32'(id_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("hold_redir_araddr", ic_araddr, 32'h8000_0200);
`ifdef IFU_PERF_EN
        check("hold_redir_perf_fetch", perf_fetch_cnt[31:0], pf0[31:0]);
        check("hold_redir_perf_squash", perf_squash_cnt[31:0], ps0[31:0]);
`endif
        wait_q(0, 10, "hold_redir_fire");
        id_ready = 1'b0;

        // Faulting fetch in a stream of hits
        do_reset(1'b1, 1'b1);
        fault_addr = 32'h8000_0010;
        for (int i = 0; i < 6; i++) begin
            push_exp(RESET_PC + 32'(4 * i), (i == 4));
        end
        wait_q(0, 30, "fault_stream");
        id_ready = 1'b0;

        // PC wrap past the top of the address space
        do_reset(1'b1, 1'b0);
        push_exp(32'hFFFF_FFFC, 1'b0);
        push_exp(32'h0000_0000, 1'b0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        wait_q(1, 10, "wrap_first_fire");
        @(negedge clk);
        check("wrap_arvalid", 32'(ic_arvalid), 32'd1);
        check("wrap_araddr", ic_araddr, 32'h0000_0000);
        wait_q(0, 10, "wrap_second_fire");
        id_ready = 1'b0;

        // Redirect while the AR is still waiting for arready
        do_reset(1'b0, 1'b1);
        ar_block = 1'b1;
        push_exp(32'h8000_0300, 1'b0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        @(negedge clk);
        check("arblk_arvalid", 32'(ic_arvalid), 32'd1);
        check("arblk_addr_held", ic_araddr, RESET_PC);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("arblk_addr_stable", ic_araddr, RESET_PC);
        step();
        ar_block = 1'b0;
        wait_q(0, 80, "arblk_fire");
        id_ready = 1'b0;

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
